// File: rtl/alu_seq.sv
// Registered nine-op ALU with valid/ready on both sides; shift-add MUL takes WIDTH extra cycles.
// Latency 1 (MUL: WIDTH+1); a held result stalls intake until out_ready retires it.
module alu_seq #(
    parameter int WIDTH  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       select,
    input  logic             in_c,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 c_q, c_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic                 is_mul;
    logic                 lt_s;
    logic [WIDTH:0]       arith;
    logic [WIDTH-1:0]     alu_s;
    logic                 alu_c;
    logic                 alu_ovf;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_step;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (MUL_EN != 0) && (select == 4'd8);
    assign lt_s      = $signed(in_x) < $signed(in_y);

    assign out_valid = (state_q == DONE);
    assign out_s     = s_q;
    assign out_c     = c_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

    // Multiplier sits in the low half of acc; each step adds the multiplicand into the high half and shifts right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        arith   = '0;
        alu_s   = '0;
        alu_c   = 1'b0;
        alu_ovf = 1'b0;
        case (select)
            4'd0: begin
                arith   = {1'b0, in_x} + {1'b0, in_y} + {{WIDTH{1'b0}}, in_c};
                alu_s   = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ovf = (in_x[MSB] == in_y[MSB]) && (alu_s[MSB] != in_x[MSB]);
            end
            4'd1: begin
                arith   = {1'b0, in_x} + {1'b0, ~in_y} + {{WIDTH{1'b0}}, ~in_c};
                alu_s   = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ovf = (in_x[MSB] != in_y[MSB]) && (alu_s[MSB] != in_x[MSB]);
            end
            4'd2:    alu_s = ~in_x;
            4'd3:    alu_s = in_x & in_y;
            4'd4:    alu_s = in_x | in_y;
            4'd5:    alu_s = in_x ^ in_y;
            4'd6:    alu_s = {{(WIDTH-1){1'b0}}, lt_s};
            4'd7:    alu_s = {{(WIDTH-1){1'b0}}, (in_x == in_y)};
            default: alu_s = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    s_d     = acc_step[WIDTH-1:0];
                    c_d     = |acc_step[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    zero_d  = (acc_step[WIDTH-1:0] == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        // A fresh accept overrides the retire path above.
        if (accept) begin
            if (is_mul) begin
                state_d = BUSY;
                acc_d   = {{WIDTH{1'b0}}, in_y};
                mcand_d = in_x;
                cnt_d   = '0;
            end else begin
                state_d = DONE;
                s_d     = alu_s;
                c_d     = alu_c;
                ovf_d   = alu_ovf;
                zero_d  = (alu_s == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model (result queue + ready time).
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   select = '0;
    logic         in_c = 1'b0;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_s;
    logic         out_c;
    logic         zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         z;
        logic         o;
        int           lat;
        int           rdy;
    } res_t;

    res_t q[$];

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .select(select), .in_c(in_c), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_c(out_c), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    // Plain-arithmetic statement of what each opcode must produce.
    function automatic res_t model(input int sel, input int x, input int y, input int ci);
        res_t e;
        int mask, msb, r, p, sx, sy;
        mask = (1 << W) - 1;
        msb  = 1 << (W - 1);
        sx   = (x & msb) != 0 ? x - (1 << W) : x;
        sy   = (y & msb) != 0 ? y - (1 << W) : y;
        e.c = 1'b0; e.o = 1'b0; e.lat = 1; e.rdy = 0; r = 0;
        case (sel)
            0: begin
                r = x + y + ci;
                e.c = ((r >> W) & 1) != 0;
                r = r & mask;
                e.o = ((x & msb) == (y & msb)) && ((r & msb) != (x & msb));
            end
            1: begin
                r = x - y - ci;
                e.c = (r >= 0);
                r = r & mask;
                e.o = ((x & msb) != (y & msb)) && ((r & msb) != (x & msb));
            end
            2: r = ~x & mask;
            3: r = x & y;
            4: r = x | y;
            5: r = x ^ y;
            6: r = (sx < sy) ? 1 : 0;
            7: r = (x == y) ? 1 : 0;
            8: begin
                p = x * y;
                r = p & mask;
                e.c = (p >> W) != 0;
                e.lat = W + 1;
            end
            default: r = 0;
        endcase
        e.s = r[W-1:0];
        e.z = (r == 0);
        return e;
    endfunction

    // Model update: a result retires when visible and taken; a bundle enters when the model says ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            bit   ev, er;
            res_t e;
            ev = (q.size() > 0) && (cyc >= q[0].rdy);
            er = (q.size() == 0) || (ev && out_ready);
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) begin
                e = model(int'(select), int'(in_x), int'(in_y), int'(in_c));
                e.rdy = cyc + e.lat;
                q.push_back(e);
            end
        end
        if (!rst || clk) cyc++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit ev, er;
            ev = (q.size() > 0) && (cyc >= q[0].rdy);
            er = (q.size() == 0) || (ev && out_ready);
            chk("mon_out_valid", out_valid, ev);
            chk("mon_in_ready", in_ready, er);
            if (ev && out_valid) begin
                chk("mon_out_s", out_s, q[0].s);
                chk("mon_out_c", out_c, q[0].c);
                chk("mon_zero", zero, q[0].z);
                chk("mon_overflow", overflow, q[0].o);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] sel, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bit done;
        select = sel; in_x = x; in_y = y; in_c = c; in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("issue_timeout", 0, 1);
    endtask

    task automatic expect_res(input string n, input logic [W-1:0] s, input logic c, input logic z, input logic o);
        @(negedge clk);
        chk({n, "_valid"}, out_valid, 1);
        chk({n, "_s"}, out_s, s);
        chk({n, "_c"}, out_c, c);
        chk({n, "_zero"}, zero, z);
        chk({n, "_ovf"}, overflow, o);
        @(posedge clk); #1;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_s", out_s, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        issue(4'd0, 4'b0111, 4'b0001, 1'b0);
        expect_res("add", 4'b1000, 1'b0, 1'b0, 1'b1);
        issue(4'd1, 4'b0011, 4'b0011, 1'b0);
        expect_res("sub0", 4'b0000, 1'b1, 1'b1, 1'b0);
        issue(4'd1, 4'b0000, 4'b0001, 1'b0);
        expect_res("sub1", 4'b1111, 1'b0, 1'b0, 1'b0);

        // MUL with a competing bundle held on the input throughout BUSY.
        issue(4'd8, 4'b1111, 4'b1111, 1'b0);
        select = 4'd0; in_x = 4'd3; in_y = 4'd4; in_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", in_ready, 0);
            chk("mul_busy_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        expect_res("mul", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Backpressure, then retire-and-accept in one cycle.
        out_ready = 1'b0;
        issue(4'd3, 4'b1100, 4'b1010, 1'b0);
        select = 4'd5; in_x = 4'b0101; in_y = 4'b0011; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_s", out_s, 4'b1000);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_res("xor", 4'b0110, 1'b0, 1'b0, 1'b0);

        // Reset in the second BUSY cycle.
        issue(4'd8, 4'd3, 4'd5, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmul_out_valid", out_valid, 0);
        chk("rstmul_out_s", out_s, 0);
        chk("rstmul_out_c", out_c, 0);
        chk("rstmul_zero", zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            chk("rstmul_post_valid", out_valid, 0);
            chk("rstmul_post_ready", in_ready, 1);
            @(posedge clk); #1;
        end

        issue(4'd6, 4'b1000, 4'b0001, 1'b0);
        expect_res("lt", 4'b0001, 1'b0, 1'b0, 1'b0);
        issue(4'd7, 4'b1010, 4'b1010, 1'b0);
        expect_res("eq", 4'b0001, 1'b0, 1'b0, 1'b0);
        issue(4'd12, 4'b1111, 4'b0110, 1'b1);
        expect_res("illegal", 4'b0000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 3) != 0;
            select    = 4'($urandom_range(0, 15));
            if ($urandom % 3 == 0) select = 4'd8;
            in_x      = W'($urandom);
            in_y      = W'($urandom);
            in_c      = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
